// File: rtl/instruction_encoder_if.sv
// Request/response bus of the instruction encoder: request fields with a
// valid/ready handshake in, encoded word with valid/ready out, plus status.
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        cond;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [3:0]        rd;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              addr_clr;
  logic              err;
  logic [7:0]        err_count;

  modport master (
    output in_valid, op, funct, cond, rn, rm, rd, imm, out_ready, addr_clr,
    input  in_ready, out_valid, out_word, out_addr, err, err_count
  );

  modport slave (
    input  in_valid, op, funct, cond, rn, rm, rd, imm, out_ready, addr_clr,
    output in_ready, out_valid, out_word, out_addr, err, err_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs request fields into a 32-bit instruction word with a one-entry output
// register and a wrapping word address. Optional macro: ENCODER_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  instruction_encoder_if.slave bus
);
  logic              out_valid_q;
  logic [31:0]       out_word_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              err_q;
  logic [7:0]        err_count_q;

  logic              accept;
  logic              reject;
  logic              out_xfer;
  logic              i_flag;
  logic              range_bad;
  logic [31:0]       word_d;

  // During reset the output register is being cleared, so the slot is free.
  assign bus.in_ready = rst || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_xfer     = out_valid_q && bus.out_ready;
  assign i_flag       = bus.funct[5];
  assign reject       = (bus.op == 2'b11) || range_bad;

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    case (bus.op)
      2'b00:   range_bad = i_flag && (bus.imm[31:8] != 24'd0);
      2'b01:   range_bad = !i_flag && (bus.imm[31:12] != 20'd0);
      2'b10:   range_bad = (bus.imm[1:0] != 2'b00) ||
                           (bus.imm[31:25] != {7{bus.imm[25]}});
      default: range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
  wire unused_imm_bits = &{1'b0, bus.imm[31:26], bus.imm[1:0]};
`endif

  always_comb begin
    word_d        = '0;
    word_d[31:28] = bus.cond;
    word_d[27:26] = bus.op;
    case (bus.op)
      2'b00: begin
        word_d[25:20] = bus.funct;
        word_d[19:16] = bus.rn;
        word_d[15:12] = bus.rd;
        if (i_flag) word_d[7:0] = bus.imm[7:0];
        else        word_d[3:0] = bus.rm;
      end
      2'b01: begin
        word_d[25:20] = bus.funct;
        word_d[19:16] = bus.rn;
        word_d[15:12] = bus.rd;
        if (i_flag) word_d[3:0]  = bus.rm;
        else        word_d[11:0] = bus.imm[11:0];
      end
      2'b10: begin
        word_d[25:24] = bus.funct[1:0];
        word_d[23:0]  = bus.imm[25:2];
      end
      default: word_d = '0;
    endcase
  end

  // Clear wins over the post-transfer increment.
  always_comb begin
    addr_d = addr_q;
    if (bus.addr_clr)  addr_d = '0;
    else if (out_xfer) addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= accept && reject;
      if (accept && reject && (err_count_q != 8'hFF))
        err_count_q <= err_count_q + 8'd1;
      if (accept && !reject) begin
        out_valid_q <= 1'b1;
        out_word_q  <= word_d;
        out_addr_q  <= addr_d;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder built with ADDR_W=2 so the
// address wrap is reached quickly; honours ENCODER_RANGE_CHECK_EN if defined.
module tb_instruction_encoder;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_encoder_if #(.ADDR_W(AW)) bus ();

  instruction_encoder #(.ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]   word;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] next_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request and hold it until the handshake completes.
  task automatic send(input logic [1:0] op_v, input logic [5:0] f_v, input logic [3:0] c_v,
                      input logic [3:0] rn_v, input logic [3:0] rm_v, input logic [3:0] rd_v,
                      input logic [31:0] imm_v, input logic legal, input logic [31:0] exp_word);
    bit ok = 0;
    bus.op = op_v; bus.funct = f_v; bus.cond = c_v;
    bus.rn = rn_v; bus.rm = rm_v; bus.rd = rd_v; bus.imm = imm_v;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for op=%0d, expected acceptance", op_v);
      bus.in_valid = 1'b0;
      return;
    end
    if (legal) begin
      sb.push_back('{exp_word, next_addr});
      $display("send op=%0d imm=0x%08h expect word=0x%08h addr=%0d", op_v, imm_v, exp_word, next_addr);
      next_addr = next_addr + 1'b1;
    end else begin
      $display("send op=%0d imm=0x%08h expect reject", op_v, imm_v);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h addr=%0d, expected no word", bus.out_word, bus.out_addr);
      end else begin
        e = sb.pop_front();
        $display("xfer word=0x%08h addr=%0d", bus.out_word, bus.out_addr);
        chk("out_word", bus.out_word, e.word);
        chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    logic [31:0]   a_word;
    logic [AW-1:0] a_addr;
    bus.in_valid = 1'b0; bus.op = '0; bus.funct = '0; bus.cond = '0;
    bus.rn = '0; bus.rm = '0; bus.rd = '0; bus.imm = '0;
    bus.out_ready = 1'b1; bus.addr_clr = 1'b0;

    idle(2);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word", bus.out_word, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Five back-to-back words: addresses 0,1,2,3,0.
    send(2'b00, 6'h28, 4'hE, 4'h1, 4'h0, 4'h2, 32'h5,        1, 32'hE2812005);
    chk("dp_imm_err", 32'(bus.err), 32'd0);
    send(2'b10, 6'h02, 4'hE, 4'h0, 4'h0, 4'h0, 32'hFFFFFFF8, 1, 32'hEAFFFFFE);
    send(2'b00, 6'h08, 4'h0, 4'h3, 4'h5, 4'h4, 32'hFF,       1, 32'h00834005);
    send(2'b01, 6'h19, 4'h1, 4'h6, 4'h0, 4'h7, 32'hABC,      1, 32'h15967ABC);
    send(2'b01, 6'h21, 4'h2, 4'h8, 4'hA, 4'h9, 32'h0,        1, 32'h2618900A);

    // Illegal op: consumed, err pulse, no word, address unchanged.
    send(2'b11, 6'h00, 4'hE, 4'h0, 4'h0, 4'h0, 32'h0, 0, 32'h0);
    chk("illegal_err_pulse", 32'(bus.err), 32'd1);
    chk("illegal_no_word", 32'(bus.out_valid), 32'd0);
    idle(1);
    chk("illegal_err_drop", 32'(bus.err), 32'd0);
    chk("illegal_err_count", 32'(bus.err_count), 32'd1);

`ifdef ENCODER_RANGE_CHECK_EN
    send(2'b00, 6'h20, 4'hE, 4'h0, 4'h0, 4'h0, 32'h100, 0, 32'h0);
    chk("range_err_pulse", 32'(bus.err), 32'd1);
    idle(1);
    chk("range_err_count", 32'(bus.err_count), 32'd2);
`else
    send(2'b00, 6'h20, 4'hE, 4'h0, 4'h0, 4'h0, 32'h100, 1, 32'hE2000000);
    chk("trunc_no_err", 32'(bus.err), 32'd0);
`endif
    idle(2);

    // Stall: first word held, second waits until the sink is ready.
    bus.out_ready = 1'b0;
    a_word = 32'h13FFE0A5;
    a_addr = next_addr;
    send(2'b00, 6'h3F, 4'h1, 4'hF, 4'h0, 4'hE, 32'hA5, 1, a_word);
    fork
      send(2'b10, 6'h03, 4'hB, 4'h0, 4'h0, 4'h0, 32'h400, 1, 32'hBB000100);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_out_word", bus.out_word, a_word);
          chk("stall_out_addr", 32'(bus.out_addr), 32'(a_addr));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("stall_second_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_second_word", bus.out_word, 32'hBB000100);
    idle(2);

    // Clear the address, then clear again together with the transfer at 2.
    bus.addr_clr = 1'b1;
    idle(1);
    bus.addr_clr = 1'b0;
    next_addr = '0;
    send(2'b00, 6'h01, 4'h3, 4'h1, 4'h0, 4'h2, 32'h0, 1, 32'h30112000);
    send(2'b00, 6'h01, 4'h3, 4'h1, 4'h1, 4'h2, 32'h0, 1, 32'h30112001);
    send(2'b00, 6'h01, 4'h3, 4'h1, 4'h2, 4'h2, 32'h0, 1, 32'h30112002);
    bus.addr_clr = 1'b1;
    next_addr = '0;
    send(2'b00, 6'h01, 4'h3, 4'h1, 4'h3, 4'h2, 32'h0, 1, 32'h30112003);
    bus.addr_clr = 1'b0;
    send(2'b00, 6'h01, 4'h3, 4'h1, 4'h4, 4'h2, 32'h0, 1, 32'h30112004);
    idle(2);

    // Reset during a stall discards the held word.
    bus.out_ready = 1'b0;
    send(2'b01, 6'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h123, 1, 32'h04000123);
    rst = 1'b1;
    idle(1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("midrst_err_count", 32'(bus.err_count), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    sb.delete();
    next_addr = '0;
    bus.out_ready = 1'b1;
    send(2'b10, 6'h01, 4'h0, 4'h0, 4'h0, 4'h0, 32'h10, 1, 32'h09000004);
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter: ADDR_W, 8, width of the output word address; the address wraps modulo 2^ADDR_W.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request fields valid.
REQ-005 Port: in_ready  output  1  encoder accepts the request this cycle.
REQ-006 Port: op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-007 Port: funct  input  6  function field; funct[5] is the I flag for op 00/01, and funct[1:0] is used for op 10.
REQ-008 Port: cond  input  4  condition code.
REQ-009 Port: rn, rm, rd  input  4 each  first operand, second operand and destination register.
REQ-010 Port: imm  input  32  immediate; for branches it is the byte offset.
REQ-011 Port: out_valid  output  1  encoded word available.
REQ-012 Port: out_ready  input  1  sink accepts the word.
REQ-013 Port: out_word  output  32  encoded instruction.
REQ-014 Port: out_addr  output  ADDR_W  word address for out_word.
REQ-015 Port: addr_clr  input  1  restart the address at 0.
REQ-016 Port: err  output  1  one-cycle pulse when a request was rejected.
REQ-017 Port: err_count  output  8  count of rejected requests, saturating.

Function
REQ-018 Common fields for every legal op: bits [31:28]=cond and [27:26]=op.
REQ-019 op 00: [25:20]=funct, [19:16]=rn, [15:12]=rd.
- I=1: [11:8]=0 and [7:0]=imm[7:0].
- I=0: [11:4]=0 and [3:0]=rm.
REQ-020 op 01: [25:20]=funct, [19:16]=rn, [15:12]=rd.
- I=1: [11:4]=0 and [3:0]=rm.
- I=0: [11:0]=imm[11:0].
REQ-021 op 10: [25:24]=funct[1:0] and [23:0]=imm[25:2].
REQ-022 op 11: the request is rejected.
REQ-023 Input handshake: a transfer occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready, evaluated combinationally.
REQ-024 Output latency: an accepted legal request sets out_valid, out_word and out_addr on the next rising edge.
REQ-025 While out_valid && !out_ready, out_word and out_addr are held stable and no new request is accepted.
REQ-026 An output transfer (out_valid && out_ready) increments the address register by 1, wrapping 2^ADDR_W-1 to 0.
REQ-027 A new request may be accepted in the same cycle as an output transfer, giving back-to-back throughput of one word per cycle.
REQ-028 A rejected request is consumed through the input handshake but produces no output word.
- err is high for exactly the one cycle after acceptance.
- The address does not advance.
- err_count increments, saturating at 255.
REQ-029 addr_clr sets the address register to 0 on the next edge.
- If addr_clr coincides with an output transfer, the current word keeps its current address and the next address is 0 (clear wins over increment).
REQ-030 out_addr of a word equals the address register at the moment the word is registered.
- addr_clr while a word is held does not alter that word's out_addr.

Reset
REQ-031 While rst is high: out_valid=0, out_word=0, out_addr=0, address register=0, err=0, err_count=0.
- Input fields are ignored; in_ready evaluates to 1.
REQ-032 A reset asserted mid-stall discards the held word, and no output transfer is reported for it.

Configuration
REQ-033 ENCODER_RANGE_CHECK_EN defined: the following requests are also rejected per REQ-028:
- op 00 with I=1 and imm[31:8]!=0;
- op 01 with I=0 and imm[31:12]!=0;
- op 10 with imm[1:0]!=0, or imm[31:25] not all equal to imm[25].
REQ-034 ENCODER_RANGE_CHECK_EN undefined: these immediates are silently truncated per REQ-019..REQ-021, and only op 11 is rejected.

Verification
REQ-035 op=00, cond=E, funct=0x28, rn=1, rd=2, imm=5, out_ready=1 -> next cycle out_word=0xE2812005, out_addr=0, err=0.
REQ-036 op=10, cond=E, funct=0x02, imm=0xFFFFFFF8 -> out_word=0xEAFFFFFE; the following word gets out_addr=1.
REQ-037 out_ready=0 for 3 cycles with two queued requests:
- First word held stable and in_ready=0 throughout.
- Second word appears on the cycle after out_ready rises.
REQ-038 op=11 request -> err pulse of 1 cycle, out_valid stays 0, err_count=1, next legal word keeps the unchanged address.
- With ENCODER_RANGE_CHECK_EN: op=00, I=1, imm=0x100 -> err, err_count=2.
- Without it: the same request emits [7:0]=0x00.
REQ-039 ADDR_W=2, five consecutive transfers -> addresses 0,1,2,3,0.
- addr_clr together with the transfer at address 2 -> subsequent addresses 0,1.
REQ-040 rst pulsed while a word is stalled -> out_valid=0, out_addr=0 and err_count=0 on the next cycle.
